// File: rtl/r3_add_sched.sv
// r3_add_sched: issues S=x1+x2, D=x1-x2, Y0=x0+S on a shared fixed-latency adder and hands {S,D,Y0} downstream
module r3_add_sched #(
  parameter int LAT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [32:0] X0F,
  input  logic [32:0] X1F,
  input  logic [32:0] X2F,
  output logic        ADD_GO,
  output logic [23:0] AA,
  output logic [7:0]  AEA,
  output logic        ASA,
  output logic [23:0] BA,
  output logic [7:0]  BEA,
  output logic        BSA,
  input  logic [23:0] RM,
  input  logic [7:0]  RE,
  input  logic        RS,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [32:0] SF,
  output logic [32:0] DF,
  output logic [32:0] Y0F
);
  typedef enum logic [2:0] {IDLE, ISS_S, ISS_D, WAIT_S, ISS_X0, WAIT_X0, DONE} state_t;
  state_t st;
  logic [32:0] x0;
  logic [LAT-1:0][1:0] tags;
  logic s_ok;
  logic [1:0] cur_tag, rt;
  logic [32:0] r, s_now;
  always_comb begin
    cur_tag = !ADD_GO ? 2'd0 : st == ISS_S ? 2'd1 : st == ISS_D ? 2'd2 : 2'd3;
    rt = tags[LAT-1];
    r = {RS, RE, RM};
    s_now = rt == 2'd1 ? r : SF;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      st <= IDLE;
      IN_READY <= 1'b0;
      ADD_GO <= 1'b0;
      {ASA, AEA, AA} <= '0;
      {BSA, BEA, BA} <= '0;
      OUT_VALID <= 1'b0;
      SF <= '0;
      DF <= '0;
      Y0F <= '0;
      x0 <= '0;
      s_ok <= 1'b0;
      tags <= '0;
    end else begin
      tags[0] <= cur_tag;
      for (int i = 1; i < LAT; i++) tags[i] <= tags[i-1];
      if (rt == 2'd1) SF <= r;
      if (rt == 2'd2) DF <= r;
      if (rt == 2'd3) Y0F <= r;
      if (rt == 2'd1) s_ok <= 1'b1;
      ADD_GO <= 1'b0;
      case (st)
        IDLE: begin
          IN_READY <= 1'b1;
          if (IN_VALID && IN_READY) begin
            x0 <= X0F;
            {ASA, AEA, AA} <= X1F;
            {BSA, BEA, BA} <= X2F;
            ADD_GO <= 1'b1;
            IN_READY <= 1'b0;
            s_ok <= 1'b0;
            st <= ISS_S;
          end
        end
        ISS_S: begin
          BSA <= ~BSA;
          ADD_GO <= 1'b1;
          st <= ISS_D;
        end
        ISS_D, WAIT_S: begin
          // S coming back this cycle is forwarded straight onto the B operand
          if (rt == 2'd1 || s_ok) begin
            {ASA, AEA, AA} <= x0;
            {BSA, BEA, BA} <= s_now;
            ADD_GO <= 1'b1;
            st <= ISS_X0;
          end else st <= WAIT_S;
        end
        ISS_X0: st <= WAIT_X0;
        WAIT_X0: begin
          if (rt == 2'd3) begin
            OUT_VALID <= 1'b1;
            st <= DONE;
          end
        end
        DONE: begin
          if (OUT_READY) begin
            OUT_VALID <= 1'b0;
            IN_READY <= 1'b1;
            st <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_r3_add_sched.sv
// tb_r3_add_sched: directed checks of the radix-3 adder scheduler at LAT=4 and LAT=1
module tb_r3_add_sched;
  logic CLK = 1'b0;
  logic RST;
  logic [32:0] X0F, X1F, X2F;
  logic iv4, ir4, go4, sa4, sb4, ov4, or4, rs4;
  logic [23:0] ma4, mb4, rm4;
  logic [7:0] ea4, eb4, re4;
  logic [32:0] sf4, df4, y04;
  logic iv1, ir1, go1, sa1, sb1, ov1, or1, rs1;
  logic [23:0] ma1, mb1, rm1;
  logic [7:0] ea1, eb1, re1;
  logic [32:0] sf1, df1, y01;
  logic [32:0] p4 [4];
  logic [32:0] p1;
  int pass_n = 0;
  int total_n = 0;

  localparam logic [32:0] F05 = {1'b0, 8'd126, 24'h800000};
  localparam logic [32:0] F1  = {1'b0, 8'd127, 24'h800000};
  localparam logic [32:0] FM1 = {1'b1, 8'd127, 24'h800000};
  localparam logic [32:0] F15 = {1'b0, 8'd127, 24'hC00000};
  localparam logic [32:0] F2  = {1'b0, 8'd128, 24'h800000};
  localparam logic [32:0] F3  = {1'b0, 8'd128, 24'hC00000};
  localparam logic [32:0] F35 = {1'b0, 8'd128, 24'hE00000};
  localparam logic [32:0] F4  = {1'b0, 8'd129, 24'h800000};
  localparam logic [32:0] F5  = {1'b0, 8'd129, 24'hA00000};

  always #5 CLK = ~CLK;

  r3_add_sched #(.LAT(4)) u4 (
    .CLK(CLK), .RST(RST), .IN_VALID(iv4), .IN_READY(ir4),
    .X0F(X0F), .X1F(X1F), .X2F(X2F),
    .ADD_GO(go4), .AA(ma4), .AEA(ea4), .ASA(sa4), .BA(mb4), .BEA(eb4), .BSA(sb4),
    .RM(rm4), .RE(re4), .RS(rs4),
    .OUT_VALID(ov4), .OUT_READY(or4), .SF(sf4), .DF(df4), .Y0F(y04)
  );

  r3_add_sched #(.LAT(1)) u1 (
    .CLK(CLK), .RST(RST), .IN_VALID(iv1), .IN_READY(ir1),
    .X0F(X0F), .X1F(X1F), .X2F(X2F),
    .ADD_GO(go1), .AA(ma1), .AEA(ea1), .ASA(sa1), .BA(mb1), .BEA(eb1), .BSA(sb1),
    .RM(rm1), .RE(re1), .RS(rs1),
    .OUT_VALID(ov1), .OUT_READY(or1), .SF(sf1), .DF(df1), .Y0F(y01)
  );

  // Behavioural adder: align, add magnitudes, renormalise (truncating)
  function automatic logic [32:0] fadd(input logic [32:0] a, input logic [32:0] b);
    logic [32:0] t;
    logic [25:0] ma, mb, m;
    logic [7:0] e;
    logic s;
    if (a[31:24] < b[31:24]) begin
      t = a;
      a = b;
      b = t;
    end
    e = a[31:24];
    ma = {2'b0, a[23:0]};
    mb = {2'b0, b[23:0]} >> (a[31:24] - b[31:24]);
    if (a[32] == b[32]) begin
      m = ma + mb;
      s = a[32];
    end else if (ma >= mb) begin
      m = ma - mb;
      s = a[32];
    end else begin
      m = mb - ma;
      s = b[32];
    end
    if (m == 26'd0) return 33'd0;
    if (m[24]) begin
      m = m >> 1;
      e = e + 8'd1;
    end
    for (int i = 0; i < 24 && !m[23]; i++) begin
      m = m << 1;
      e = e - 8'd1;
    end
    return {s, e, m[23:0]};
  endfunction

  always @(posedge CLK) begin
    p4[0] <= go4 ? fadd({sa4, ea4, ma4}, {sb4, eb4, mb4}) : 33'd0;
    for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
    p1 <= go1 ? fadd({sa1, ea1, ma1}, {sb1, eb1, mb1}) : 33'd0;
  end
  assign {rs4, re4, rm4} = p4[3];
  assign {rs1, re1, rm1} = p1;

  task automatic test_reset();
    RST = 1'b1;
    @(negedge CLK);
    total_n++;
    if ({ir4, go4, ov4, sa4, ea4, ma4, sb4, eb4, mb4, sf4, df4, y04} !== '0)
      $display("FAIL reset_u4: got ir=%b go=%b ov=%b sf=%h df=%h y0=%h, want all 0", ir4, go4, ov4, sf4, df4, y04);
    else pass_n++;
    total_n++;
    if ({ir1, go1, ov1, sa1, ea1, ma1, sb1, eb1, mb1, sf1, df1, y01} !== '0)
      $display("FAIL reset_u1: got ir=%b go=%b ov=%b sf=%h df=%h y0=%h, want all 0", ir1, go1, ov1, sf1, df1, y01);
    else pass_n++;
    RST = 1'b0;
    @(negedge CLK);
    total_n++;
    if ({ir4, ir1} !== 2'b11) $display("FAIL reset_ready: got %b want 11", {ir4, ir1});
    else pass_n++;
  endtask

  task automatic test_triplet(input bit one, input logic [32:0] a, b, c, es, ed, ey, input string nm);
    int gc3, ovc;
    logic g, o, r, bs;
    logic [32:0] av, bv, sv, dv, yv;
    gc3 = one ? 3 : 6;
    ovc = one ? 5 : 11;
    for (int k = 0; k < 20 && !(one ? ir1 : ir4); k++) @(negedge CLK);
    total_n++;
    if (!(one ? ir1 : ir4)) $display("FAIL %s_ready: got 0 want 1", nm);
    else pass_n++;
    X0F = a;
    X1F = b;
    X2F = c;
    if (one) begin iv1 = 1'b1; or1 = 1'b1; end
    else begin iv4 = 1'b1; or4 = 1'b1; end
    for (int cy = 1; cy <= ovc + 1; cy++) begin
      @(negedge CLK);
      iv1 = 1'b0;
      iv4 = 1'b0;
      g = one ? go1 : go4;
      o = one ? ov1 : ov4;
      r = one ? ir1 : ir4;
      bs = one ? sb1 : sb4;
      av = one ? {sa1, ea1, ma1} : {sa4, ea4, ma4};
      bv = one ? {sb1, eb1, mb1} : {sb4, eb4, mb4};
      sv = one ? sf1 : sf4;
      dv = one ? df1 : df4;
      yv = one ? y01 : y04;
      total_n++;
      if (g !== (cy == 1 || cy == 2 || cy == gc3)) $display("FAIL %s_go c%0d: got %b", nm, cy, g);
      else pass_n++;
      total_n++;
      if (o !== (cy == ovc)) $display("FAIL %s_ov c%0d: got %b", nm, cy, o);
      else pass_n++;
      if (cy == 1) begin
        total_n++;
        if ({av, bv} !== {b, c}) $display("FAIL %s_ops_s: got a=%h b=%h want a=%h b=%h", nm, av, bv, b, c);
        else pass_n++;
      end
      if (cy == 2) begin
        total_n++;
        if (bs !== ~c[32]) $display("FAIL %s_dsign: got %b want %b", nm, bs, ~c[32]);
        else pass_n++;
      end
      if (cy == gc3) begin
        total_n++;
        if ({av, bv} !== {a, es}) $display("FAIL %s_ops_y0: got a=%h b=%h want a=%h b=%h", nm, av, bv, a, es);
        else pass_n++;
      end
      if (cy == ovc) begin
        total_n++;
        if ({sv, dv, yv} !== {es, ed, ey})
          $display("FAIL %s_res: got s=%h d=%h y0=%h want s=%h d=%h y0=%h", nm, sv, dv, yv, es, ed, ey);
        else pass_n++;
      end
      if (cy == ovc + 1) begin
        total_n++;
        if (r !== 1'b1) $display("FAIL %s_ready_after: got %b want 1", nm, r);
        else pass_n++;
      end
    end
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 20 && !ir4; k++) @(negedge CLK);
    X0F = F2;
    X1F = F1;
    X2F = F05;
    iv4 = 1'b1;
    or4 = 1'b0;
    for (int k = 0; k < 20 && !ov4; k++) @(negedge CLK);
    total_n++;
    if (!ov4) $display("FAIL bp_ov_timeout: got 0 want 1");
    else pass_n++;
    for (int k = 0; k < 5; k++) begin
      total_n++;
      if ({ov4, ir4, go4} !== 3'b100) $display("FAIL bp_hold k%0d: got ov/ir/go=%b want 100", k, {ov4, ir4, go4});
      else pass_n++;
      total_n++;
      if ({sf4, df4, y04} !== {F15, F05, F35}) $display("FAIL bp_data k%0d: got %h %h %h", k, sf4, df4, y04);
      else pass_n++;
      @(negedge CLK);
    end
    or4 = 1'b1;
    iv4 = 1'b0;
    @(negedge CLK);
    total_n++;
    if ({ov4, ir4, go4} !== 3'b010) $display("FAIL bp_release: got ov/ir/go=%b want 010", {ov4, ir4, go4});
    else pass_n++;
  endtask

  task automatic test_mid_reset();
    for (int k = 0; k < 20 && !ir4; k++) @(negedge CLK);
    X0F = F2;
    X1F = F1;
    X2F = F05;
    iv4 = 1'b1;
    or4 = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      iv4 = 1'b0;
    end
    total_n++;
    if (go4 !== 1'b0) $display("FAIL mr_wait_s: got go=%b want 0", go4);
    else pass_n++;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    total_n++;
    if ({ir4, go4, ov4, sa4, ea4, ma4, sb4, eb4, mb4, sf4, df4, y04} !== '0)
      $display("FAIL mr_clear: got ir=%b go=%b ov=%b sf=%h df=%h y0=%h, want all 0", ir4, go4, ov4, sf4, df4, y04);
    else pass_n++;
    @(negedge CLK);
    total_n++;
    if (ir4 !== 1'b1) $display("FAIL mr_ready: got %b want 1", ir4);
    else pass_n++;
    repeat (2) @(negedge CLK);
    total_n++;
    if ({sf4, df4, ov4} !== '0) $display("FAIL mr_stale: got sf=%h df=%h ov=%b want 0", sf4, df4, ov4);
    else pass_n++;
    test_triplet(1'b0, F1, F3, F1, F4, F2, F5, "mr_next");
  endtask

  task automatic test_back_to_back();
    bit eg;
    for (int k = 0; k < 20 && !ir4; k++) @(negedge CLK);
    X0F = F2;
    X1F = F1;
    X2F = F05;
    iv4 = 1'b1;
    or4 = 1'b1;
    for (int cy = 1; cy <= 24; cy++) begin
      @(negedge CLK);
      eg = (cy == 1 || cy == 2 || cy == 6 || cy == 13 || cy == 14 || cy == 18);
      total_n++;
      if (go4 !== eg) $display("FAIL b2b_go c%0d: got %b want %b", cy, go4, eg);
      else pass_n++;
      total_n++;
      if (ov4 !== (cy == 11 || cy == 23)) $display("FAIL b2b_ov c%0d: got %b", cy, ov4);
      else pass_n++;
      total_n++;
      if (ir4 !== (cy == 12 || cy == 24)) $display("FAIL b2b_ready c%0d: got %b", cy, ir4);
      else pass_n++;
      if (cy == 23) iv4 = 1'b0;
    end
  endtask

  initial begin
    RST = 1'b1;
    X0F = '0;
    X1F = '0;
    X2F = '0;
    iv4 = 1'b0;
    iv1 = 1'b0;
    or4 = 1'b0;
    or1 = 1'b0;
    test_reset();
    test_triplet(1'b0, F2, F1, F05, F15, F05, F35, "basic4");
    test_triplet(1'b1, F2, F1, F05, F15, F05, F35, "basic1");
    test_triplet(1'b0, F1, F3, FM1, F2, F4, F3, "neg4");
    test_triplet(1'b1, F1, F3, FM1, F2, F4, F3, "neg1");
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
